// File: rtl/trace_event_collector_if.sv
// Event stream between the trace event collector and its consumer
// (a stdout or host bridge).
//   event_valid  FIFO head valid                  (collector -> consumer)
//   event_ready  consumer accepts the head        (consumer -> collector)
//   event_type   0=EXIT 1=REPORT 2=PUTC           (collector -> consumer)
//   event_data   r3 value at the l.nop            (collector -> consumer)
//   event_pc     PC of the l.nop                  (collector -> consumer)
//   event_id     core index                       (collector -> consumer)
interface trace_event_collector_if;
  logic        event_valid;
  logic        event_ready;
  logic [1:0]  event_type;
  logic [31:0] event_data;
  logic [31:0] event_pc;
  logic [15:0] event_id;

  modport master (
    output event_valid, event_type, event_data, event_pc, event_id,
    input  event_ready
  );

  modport slave (
    input  event_valid, event_type, event_data, event_pc, event_id,
    output event_ready
  );
endinterface

// File: rtl/trace_event_collector.sv
// Extracts simulation-control l.nop events (EXIT, REPORT, PUTC) from one
// core's retired-instruction trace. Each event carries the core's shadowed
// r3 and is queued in a FIFO towards a valid/ready consumer. Once EXIT has
// been seen, later events are ignored, and terminated rises after the queue
// has drained.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   trace_*        retired instruction valid/pc/insn and register writeback
//   ev             event stream (master side), head outputs are registered
//   drop_cnt       saturating count of events lost to a full FIFO
//   terminated     EXIT seen and FIFO drained, sticky until rst
module trace_event_collector #(
  parameter int FIFO_DEPTH     = 8,
  parameter int ID             = 0,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trace_valid,
  input  logic [31:0]               trace_pc,
  input  logic [31:0]               trace_insn,
  input  logic                      trace_wben,
  input  logic [4:0]                trace_wbreg,
  input  logic [31:0]               trace_wbdata,
  trace_event_collector_if.master   ev,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt,
  output logic                      terminated
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = {DROP_CNT_WIDTH{1'b1}};
  localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = DROP_CNT_WIDTH'(1);
  localparam logic [1:0] TYPE_EXIT   = 2'd0;
  localparam logic [1:0] TYPE_REPORT = 2'd1;
  localparam logic [1:0] TYPE_PUTC   = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
    logic [31:0] pc;
  } entry_t;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [31:0]      r3;
  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] count_after_pop;
  entry_t           head;
  entry_t           head_next;
  entry_t           push_entry;
  logic             head_valid;
  logic             ev_hit;
  logic [1:0]       ev_kind;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             drop;
  logic             unused_insn_bits;

  assign unused_insn_bits = ^trace_insn[23:16];

  assign ev.event_valid = head_valid;
  assign ev.event_type  = head.kind;
  assign ev.event_data  = head.data;
  assign ev.event_pc    = head.pc;
  assign ev.event_id    = 16'(ID);

  // Decode l.nop K values into event kinds
  always_comb begin
    ev_hit  = 1'b0;
    ev_kind = TYPE_EXIT;
    if (trace_valid && (trace_insn[31:24] == 8'h15)) begin
      case (trace_insn[15:0])
        16'h0001: begin ev_hit = 1'b1; ev_kind = TYPE_EXIT;   end
        16'h0002: begin ev_hit = 1'b1; ev_kind = TYPE_REPORT; end
        16'h0004: begin ev_hit = 1'b1; ev_kind = TYPE_PUTC;   end
        default:  begin ev_hit = 1'b0; ev_kind = TYPE_EXIT;   end
      endcase
    end else begin
      ev_hit  = 1'b0;
      ev_kind = TYPE_EXIT;
    end
  end

  // FIFO push/pop/drop decisions and next head contents
  always_comb begin
    pop             = (count != CNT_ZERO) && ev.event_ready;
    push_req        = ev_hit && (state == S_RUN);
    // A full FIFO still accepts when the head leaves in the same cycle.
    push            = push_req && ((count < DEPTH_C) || pop);
    drop            = push_req && !push;
    // The event uses r3 as it stood before this instruction retired.
    push_entry      = '{kind: ev_kind, data: r3, pc: trace_pc};
    rd_next         = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
    count_after_pop = count - CNT_W'(pop);
    count_next      = count_after_pop + CNT_W'(push);
    // Older entries stay ahead of this cycle's push; an empty queue shows
    // the new entry next cycle (no same-cycle bypass).
    if (count_after_pop != CNT_ZERO) begin
      head_next = mem[rd_next];
    end else if (push) begin
      head_next = push_entry;
    end else begin
      head_next = head;
    end
  end

  // Event storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // FIFO pointers, occupancy and registered head outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= {PTR_W{1'b0}};
      rd_ptr     <= {PTR_W{1'b0}};
      count      <= CNT_ZERO;
      head_valid <= 1'b0;
      head       <= '{kind: 2'd0, data: 32'd0, pc: 32'd0};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      rd_ptr     <= rd_next;
      count      <= count_next;
      head_valid <= (count_next != CNT_ZERO);
      head       <= head_next;
    end
  end

  // r3 shadow and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r3       <= 32'd0;
      drop_cnt <= {DROP_CNT_WIDTH{1'b0}};
    end else begin
      if (trace_valid && trace_wben && (trace_wbreg == 5'd3)) begin
        r3 <= trace_wbdata;
      end
      if (drop && (drop_cnt != DROP_MAX)) begin
        drop_cnt <= drop_cnt + DROP_ONE;
      end
    end
  end

  // Run/drain/done sequencing with the sticky terminated output
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RUN;
      terminated <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (push_req && (ev_kind == TYPE_EXIT)) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (count_next == CNT_ZERO) begin
            state      <= S_DONE;
            terminated <= 1'b1;
          end
        end
        S_DONE: begin
          state      <= S_DONE;
          terminated <= 1'b1;
        end
        default: begin
          state      <= S_RUN;
          terminated <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_trace_event_collector.sv
// Self-checking bench for trace_event_collector: reset values, a table of
// single-event vectors, hand-written FIFO full/drain/reset sequences, and a
// randomized run compared against a queue-based reference model.
module tb_trace_event_collector;
  localparam int DEPTH = 8;
  localparam int DW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trace_valid = 1'b0;
  logic [31:0]   trace_pc = 32'd0;
  logic [31:0]   trace_insn = 32'd0;
  logic          trace_wben = 1'b0;
  logic [4:0]    trace_wbreg = 5'd0;
  logic [31:0]   trace_wbdata = 32'd0;
  logic [DW-1:0] drop_cnt;
  logic          terminated;

  trace_event_collector_if evif();

  trace_event_collector #(.FIFO_DEPTH(DEPTH), .ID(5), .DROP_CNT_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_insn(trace_insn), .trace_wben(trace_wben), .trace_wbreg(trace_wbreg),
    .trace_wbdata(trace_wbdata), .ev(evif), .drop_cnt(drop_cnt), .terminated(terminated)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model: queue of {type, data, pc}
  logic [65:0] mq[$];
  int          mdrop = 0;
  bit          mexit = 1'b0;
  bit          mterm = 1'b0;
  logic [31:0] mr3   = 32'd0;

  typedef struct {
    logic [31:0] r3;
    logic [7:0]  opc;
    logic [15:0] k;
    logic [31:0] pc;
    logic [31:0] samewb;
    bit          exp_valid;
    logic [1:0]  exp_type;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit v, input logic [31:0] pc, input logic [31:0] insn,
                            input bit wben, input logic [4:0] wbreg, input logic [31:0] wbdata,
                            input bit rdy, input bit r);
    bit          hit;
    bit          pop;
    bit          was_exit;
    int          sz;
    logic [1:0]  t;
    logic [65:0] tmp;
    if (r) begin
      mq.delete();
      mdrop = 0; mexit = 1'b0; mterm = 1'b0; mr3 = 32'd0;
      return;
    end
    hit = 1'b0; t = 2'd0;
    if (v && insn[31:24] == 8'h15) begin
      if (insn[15:0] == 16'h0001) begin hit = 1'b1; t = 2'd0; end
      else if (insn[15:0] == 16'h0002) begin hit = 1'b1; t = 2'd1; end
      else if (insn[15:0] == 16'h0004) begin hit = 1'b1; t = 2'd2; end
    end
    was_exit = mexit;
    sz  = mq.size();
    pop = (sz > 0) && rdy;
    if (pop) tmp = mq.pop_front();
    if (hit && !was_exit) begin
      if (sz < DEPTH || pop) mq.push_back({t, mr3, pc});
      else if (mdrop < (1 << DW) - 1) mdrop++;
      if (t == 2'd0) mexit = 1'b1;
    end
    if (was_exit && mq.size() == 0) mterm = 1'b1;
    if (v && wben && wbreg == 5'd3) mr3 = wbdata;
  endtask

  task automatic cyc(input bit v, input logic [31:0] pc, input logic [31:0] insn,
                     input bit wben, input logic [4:0] wbreg, input logic [31:0] wbdata,
                     input bit rdy, input bit r);
    rst = r; trace_valid = v; trace_pc = pc; trace_insn = insn;
    trace_wben = wben; trace_wbreg = wbreg; trace_wbdata = wbdata; evif.event_ready = rdy;
    model_step(v, pc, insn, wben, wbreg, wbdata, rdy, r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, rdy, 1'b0);
  endtask

  task automatic wb_r3(input logic [31:0] d, input bit rdy);
    cyc(1'b1, 32'h0000_0040, 32'hE000_0000, 1'b1, 5'd3, d, rdy, 1'b0);
  endtask

  task automatic nop(input logic [15:0] k, input logic [31:0] pc, input bit rdy);
    cyc(1'b1, pc, {8'h15, 8'h00, k}, 1'b0, 5'd0, 32'd0, rdy, 1'b0);
  endtask

  task automatic nopwb(input logic [15:0] k, input logic [31:0] pc, input logic [31:0] d,
                       input bit rdy);
    cyc(1'b1, pc, {8'h15, 8'h00, k}, 1'b1, 5'd3, d, rdy, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
  endtask

  function automatic logic [65:0] head_now();
    return {evif.event_type, evif.event_data, evif.event_pc};
  endfunction

  task automatic check_model();
    check("rnd_valid", 66'(evif.event_valid), 66'(mq.size() != 0));
    if (mq.size() != 0) check("rnd_head", head_now(), mq[0]);
    check("rnd_drop", 66'(drop_cnt), 66'(mdrop));
    check("rnd_term", 66'(terminated), 66'(mterm));
  endtask

  initial begin
    logic [31:0] exp_pc;
    logic [1:0]  exp_t [3];
    logic [31:0] exp_d [3];
    int          term_cnt;
    int          sel;
    logic [31:0] insn;
    bit          rdy;
    bit          r;

    vt[0] = '{r3: 32'h0000_000A, opc: 8'h15, k: 16'h0002, pc: 32'h0000_0200, samewb: 32'h0000_000B,
              exp_valid: 1'b1, exp_type: 2'd1, exp_data: 32'h0000_000A};
    vt[1] = '{r3: 32'h0000_0041, opc: 8'h15, k: 16'h0004, pc: 32'h0000_0204, samewb: 32'h0000_0099,
              exp_valid: 1'b1, exp_type: 2'd2, exp_data: 32'h0000_0041};
    vt[2] = '{r3: 32'h0000_0001, opc: 8'h15, k: 16'h0003, pc: 32'h0000_0208, samewb: 32'h0000_0000,
              exp_valid: 1'b0, exp_type: 2'd0, exp_data: 32'h0000_0000};
    vt[3] = '{r3: 32'h0000_0005, opc: 8'h14, k: 16'h0004, pc: 32'h0000_020C, samewb: 32'h0000_0006,
              exp_valid: 1'b0, exp_type: 2'd0, exp_data: 32'h0000_0000};
    vt[4] = '{r3: 32'hFFFF_FFFF, opc: 8'h15, k: 16'h0002, pc: 32'hFFFF_FFFC, samewb: 32'h1234_5678,
              exp_valid: 1'b1, exp_type: 2'd1, exp_data: 32'hFFFF_FFFF};
    vt[5] = '{r3: 32'h1234_5678, opc: 8'h15, k: 16'h0104, pc: 32'h0000_0210, samewb: 32'h0000_0000,
              exp_valid: 1'b0, exp_type: 2'd0, exp_data: 32'h0000_0000};

    // reset state
    do_reset();
    check("rst_valid", 66'(evif.event_valid), 66'(0));
    check("rst_head", head_now(), 66'(0));
    check("rst_drop", 66'(drop_cnt), 66'(0));
    check("rst_term", 66'(terminated), 66'(0));
    check("event_id", 66'(evif.event_id), 66'(5));

    // PUTC with r3 = 0x48, one-cycle latency
    wb_r3(32'h48, 1'b1);
    nop(16'h0004, 32'h100, 1'b1);
    check("putc_basic", {62'(0), evif.event_valid, 3'b0} | 66'(head_now()) , 66'({1'b1, 3'b0}) | {2'd2, 32'h48, 32'h100});
    idle(1'b1);
    check("putc_popped", 66'(evif.event_valid), 66'(0));

    // table-driven single events
    for (int i = 0; i < 6; i++) begin
      wb_r3(vt[i].r3, 1'b1);
      nopwb(vt[i].k, vt[i].pc, vt[i].samewb, 1'b1);
      if (vt[i].opc != 8'h15) begin
        cyc(1'b1, vt[i].pc, {vt[i].opc, 8'h00, vt[i].k}, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      end
      check("vec_valid", 66'(evif.event_valid), 66'(vt[i].exp_valid));
      if (vt[i].exp_valid) check("vec_fields", head_now(), {vt[i].exp_type, vt[i].exp_data, vt[i].pc});
      idle(1'b1);
      check("vec_drain", 66'(evif.event_valid), 66'(0));
    end

    // overflow: 10 PUTC into 8 entries
    do_reset();
    wb_r3(32'd100, 1'b0);
    for (int i = 0; i < 10; i++) nopwb(16'h0004, 32'h300 + 32'(4 * i), 32'(101 + i), 1'b0);
    check("ovf_drop", 66'(drop_cnt), 66'(2));
    for (int j = 0; j < 8; j++) begin
      check("ovf_order", head_now(), {2'd2, 32'(100 + j), 32'h300 + 32'(4 * j)});
      idle(1'b1);
    end
    check("ovf_empty", 66'(evif.event_valid), 66'(0));
    check("ovf_drop_kept", 66'(drop_cnt), 66'(2));

    // full FIFO with push and pop in the same cycle
    do_reset();
    wb_r3(32'd200, 1'b0);
    for (int i = 0; i < 8; i++) nopwb(16'h0004, 32'h400 + 32'(4 * i), 32'(201 + i), 1'b0);
    check("full_drop0", 66'(drop_cnt), 66'(0));
    check("full_head", head_now(), {2'd2, 32'd200, 32'h400});
    nop(16'h0004, 32'h420, 1'b1);
    check("pp_drop0", 66'(drop_cnt), 66'(0));
    for (int j = 0; j < 8; j++) begin
      exp_pc = (j < 7) ? 32'h404 + 32'(4 * j) : 32'h420;
      check("pp_order", head_now(), {2'd2, 32'(201 + j), exp_pc});
      idle(1'b1);
    end
    check("pp_empty", 66'(evif.event_valid), 66'(0));

    // EXIT drains, later events ignored, terminated after last pop
    do_reset();
    wb_r3(32'h61, 1'b0);
    nop(16'h0004, 32'h500, 1'b0);
    nop(16'h0004, 32'h504, 1'b0);
    wb_r3(32'h0, 1'b0);
    nop(16'h0001, 32'h508, 1'b0);
    check("exit_term0", 66'(terminated), 66'(0));
    nopwb(16'h0004, 32'h50C, 32'h77, 1'b0);
    idle(1'b0);
    check("drain_term0", 66'(terminated), 66'(0));
    check("drain_nodrop", 66'(drop_cnt), 66'(0));
    exp_t = '{2'd2, 2'd2, 2'd0};
    exp_d = '{32'h61, 32'h61, 32'h0};
    for (int j = 0; j < 3; j++) begin
      check("drain_order", head_now(), {exp_t[j], exp_d[j], 32'h500 + 32'(4 * j)});
      check("drain_term_wait", 66'(terminated), 66'(0));
      idle(1'b1);
    end
    check("done_valid", 66'(evif.event_valid), 66'(0));
    check("done_term", 66'(terminated), 66'(1));
    nop(16'h0004, 32'h510, 1'b1);
    idle(1'b1);
    check("done_sticky", 66'(terminated), 66'(1));
    check("done_ignored", 66'(evif.event_valid), 66'(0));

    // reset in the middle of a drain
    do_reset();
    wb_r3(32'h33, 1'b0);
    for (int i = 0; i < 10; i++) nop(16'h0004, 32'h600 + 32'(4 * i), 1'b0);
    nop(16'h0001, 32'h640, 1'b0);
    check("mid_drop", 66'(drop_cnt), 66'(3));
    nop(16'h0004, 32'h644, 1'b0);
    check("mid_drain_nodrop", 66'(drop_cnt), 66'(3));
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    check("mid_rst_valid", 66'(evif.event_valid), 66'(0));
    check("mid_rst_drop", 66'(drop_cnt), 66'(0));
    check("mid_rst_term", 66'(terminated), 66'(0));
    nop(16'h0004, 32'h700, 1'b0);
    check("mid_rst_accept", {65'(0), evif.event_valid}, 66'(1));
    check("mid_rst_head", head_now(), {2'd2, 32'd0, 32'h700});

    // randomized run against the reference model
    do_reset();
    term_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 30)      insn = {8'h15, 8'($urandom), 16'h0004};
      else if (sel < 42) insn = {8'h15, 8'($urandom), 16'h0002};
      else if (sel < 44) insn = {8'h15, 8'($urandom), 16'h0001};
      else if (sel < 52) insn = {8'h15, 8'($urandom), 16'($urandom_range(0, 8))};
      else               insn = $urandom;
      if (((n / 200) % 2) == 0) rdy = ($urandom_range(0, 3) == 0);
      else                      rdy = ($urandom_range(0, 3) != 0);
      if (mterm) term_cnt++;
      r = (term_cnt >= 10) || ($urandom_range(0, 499) == 0);
      if (r) term_cnt = 0;
      cyc(($urandom_range(0, 4) != 0), $urandom, insn, $urandom_range(0, 1) == 1,
          ($urandom_range(0, 1) == 1) ? 5'd3 : 5'($urandom), $urandom, rdy, r);
      check_model();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
